// File: rtl/access_sequencer.sv
// rtl/access_sequencer.sv - code-entry access sequencer with lockout; optional entry timeout under ACCESS_TIMEOUT_EN
module access_sequencer #(
  parameter logic [5:0] PASSWORD       = 6'b101101,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCK_CYCLES    = 1000,
  parameter int         TIMEOUT_CYCLES = 5000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Switch,
  input  logic       PushB,
  input  logic       Logout,
  output logic       Granted,
  output logic       Locked,
  output logic       GreenLed,
  output logic       RedLed,
  output logic [2:0] BitIdx,
  output logic [1:0] FailCnt
);

  typedef enum logic [1:0] {IDLE, ENTRY, GRANTED, LOCKOUT} state_t;

  localparam logic [15:0] LOCK_LOAD  = 16'(LOCK_CYCLES - 1);
  localparam logic [1:0]  FAIL_LIMIT = 2'(MAX_FAILS);

  // Parameter sanity is checked at elaboration so a bad build never reaches silicon.
  if (MAX_FAILS < 1 || MAX_FAILS > 3 || LOCK_CYCLES < 1 || LOCK_CYCLES > 65536 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_params
    $error("access_sequencer: parameter out of range");
  end

  state_t      state_q;
  logic        pushb_q;
  logic        match_q;
  logic        granted_q;
  logic        locked_q;
  logic        red_q;
  logic [2:0]  bit_idx_q;
  logic [1:0]  fail_q;
  logic [15:0] lock_cnt_q;
`ifdef ACCESS_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_q;
`endif

  logic       press;
  logic [2:0] pw_sel;
  logic       bit_ok;
  logic       match_d;
  logic [1:0] fail_d;

  assign press   = PushB & ~pushb_q;
  assign pw_sel  = 3'd5 - bit_idx_q;
  assign bit_ok  = (Switch == PASSWORD[pw_sel]);
  assign match_d = match_q & bit_ok;
  assign fail_d  = (fail_q == FAIL_LIMIT) ? fail_q : fail_q + 2'd1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      pushb_q    <= 1'b0;
      match_q    <= 1'b0;
      granted_q  <= 1'b0;
      locked_q   <= 1'b0;
      red_q      <= 1'b0;
      bit_idx_q  <= 3'd0;
      fail_q     <= 2'd0;
      lock_cnt_q <= 16'd0;
`ifdef ACCESS_TIMEOUT_EN
      idle_q     <= 16'd0;
`endif
    end else begin
      pushb_q <= PushB;
      case (state_q)
        IDLE: begin
          // The starting press only arms entry; Switch is not a code bit here.
          if (press) begin
            state_q   <= ENTRY;
            bit_idx_q <= 3'd0;
            match_q   <= 1'b1;
            red_q     <= 1'b0;
`ifdef ACCESS_TIMEOUT_EN
            idle_q    <= 16'd0;
`endif
          end
        end

        ENTRY: begin
          if (press) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            match_q   <= match_d;
`ifdef ACCESS_TIMEOUT_EN
            idle_q    <= 16'd0;
`endif
            if (bit_idx_q == 3'd5) begin
              if (match_d) begin
                state_q   <= GRANTED;
                granted_q <= 1'b1;
                fail_q    <= 2'd0;
              end else begin
                red_q  <= 1'b1;
                fail_q <= fail_d;
                if (fail_d == FAIL_LIMIT) begin
                  state_q    <= LOCKOUT;
                  locked_q   <= 1'b1;
                  lock_cnt_q <= LOCK_LOAD;
                end else begin
                  state_q <= IDLE;
                end
              end
            end
          end
`ifdef ACCESS_TIMEOUT_EN
          else if (idle_q == TMO_LAST) begin
            state_q   <= IDLE;
            bit_idx_q <= 3'd0;
          end else begin
            idle_q <= idle_q + 16'd1;
          end
`endif
        end

        GRANTED: begin
          if (Logout) begin
            state_q   <= IDLE;
            granted_q <= 1'b0;
          end
        end

        LOCKOUT: begin
          // Counter loaded with LOCK_CYCLES-1 so Locked spans exactly LOCK_CYCLES clocks.
          if (lock_cnt_q == 16'd0) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            fail_q   <= 2'd0;
            red_q    <= 1'b0;
          end else begin
            lock_cnt_q <= lock_cnt_q - 16'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign Granted  = granted_q;
  assign GreenLed = granted_q;
  assign Locked   = locked_q;
  assign RedLed   = red_q;
  assign BitIdx   = bit_idx_q;
  assign FailCnt  = fail_q;

endmodule

// File: tb/tb_access_sequencer.sv
// tb/tb_access_sequencer.sv - scoreboard bench for access_sequencer
module tb_access_sequencer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Switch;
  logic       PushB;
  logic       Logout;
  logic       Granted;
  logic       Locked;
  logic       GreenLed;
  logic       RedLed;
  logic [2:0] BitIdx;
  logic [1:0] FailCnt;

  always #5 Clk = ~Clk;

  access_sequencer #(
    .PASSWORD       (6'b101101),
    .MAX_FAILS      (3),
    .LOCK_CYCLES    (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Switch   (Switch),
    .PushB    (PushB),
    .Logout   (Logout),
    .Granted  (Granted),
    .Locked   (Locked),
    .GreenLed (GreenLed),
    .RedLed   (RedLed),
    .BitIdx   (BitIdx),
    .FailCnt  (FailCnt)
  );

  typedef struct {
    string      tag;
    logic       g;
    logic       l;
    logic       r;
    logic [2:0] bi;
    logic [1:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [5:0] GOOD = 6'b101101;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic g, input logic l, input logic r,
                         input logic [2:0] bi, input logic [1:0] fc);
    exp_t e;
    e.tag = tag; e.g = g; e.l = l; e.r = r; e.bi = bi; e.fc = fc;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    e = sb_q.pop_front();
    chk({e.tag, ".granted"}, 8'(Granted),  8'(e.g));
    chk({e.tag, ".green"},   8'(GreenLed), 8'(e.g));
    chk({e.tag, ".locked"},  8'(Locked),   8'(e.l));
    chk({e.tag, ".red"},     8'(RedLed),   8'(e.r));
    chk({e.tag, ".bitidx"},  8'(BitIdx),   8'(e.bi));
    chk({e.tag, ".failcnt"}, 8'(FailCnt),  8'(e.fc));
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic step(input string tag, input logic g, input logic l, input logic r,
                      input logic [2:0] bi, input logic [1:0] fc);
    sb_push(tag, g, l, r, bi, fc);
    tick();
    sb_check();
  endtask

  task automatic press(input logic sw, input string tag, input logic g, input logic l,
                       input logic r, input logic [2:0] bi, input logic [1:0] fc);
    Switch = sw;
    PushB  = 1'b1;
    step(tag, g, l, r, bi, fc);
    PushB  = 1'b0;
    tick();
  endtask

  // Full attempt: start press plus six code presses; final expectation supplied by caller.
  task automatic attempt(input logic [5:0] code, input string tag, input logic [1:0] fc0,
                         input logic eg, input logic el, input logic er, input logic [1:0] efc);
    press(1'b0, {tag, ".start"}, 1'b0, 1'b0, 1'b0, 3'd0, fc0);
    for (int i = 0; i < 5; i++)
      press(code[5-i], {tag, ".bit"}, 1'b0, 1'b0, 1'b0, 3'(i + 1), fc0);
    press(code[0], {tag, ".last"}, eg, el, er, 3'd6, efc);
  endtask

  initial begin
    Rst = 1'b1; Switch = 1'b0; PushB = 1'b0; Logout = 1'b0;
    step("reset", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    Rst = 1'b0;

    // Good code, press ignored while granted, then logout.
    attempt(GOOD, "ok", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    press(1'b0, "grant_press", 1'b1, 1'b0, 1'b0, 3'd6, 2'd0);
    Logout = 1'b1;
    step("logout", 1'b0, 1'b0, 1'b0, 3'd6, 2'd0);
    Logout = 1'b0;

    // Three wrong attempts drive lockout.
    attempt(6'b111101, "bad1", 2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    attempt(6'b001101, "bad2", 2'd1, 1'b0, 1'b0, 1'b1, 2'd2);
    attempt(6'b101100, "bad3", 2'd2, 1'b0, 1'b1, 1'b1, 2'd3);
    // Locked set at E0, press task already consumed E1; E2..E7 must stay locked, E8 releases.
    Logout = 1'b1;
    for (int k = 2; k <= 7; k++) begin
      PushB = (k % 2 == 0);
      step("lock_hold", 1'b0, 1'b1, 1'b1, 3'd6, 2'd3);
    end
    PushB = 1'b1;
    step("unlock", 1'b0, 1'b0, 1'b0, 3'd6, 2'd0);
    Logout = 1'b0;
    step("unlock_press_ignored", 1'b0, 1'b0, 1'b0, 3'd6, 2'd0);
    PushB = 1'b0;
    tick();

    attempt(GOOD, "ok2", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    Logout = 1'b1;
    step("logout2", 1'b0, 1'b0, 1'b0, 3'd6, 2'd0);
    Logout = 1'b0;

    // Reset mid-entry, then held button counts once.
    press(1'b0, "mid.start", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++)
      press(GOOD[5-i], "mid.bit", 1'b0, 1'b0, 1'b0, 3'(i + 1), 2'd0);
    Rst = 1'b1;
    step("rst_mid", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    Rst = 1'b0;
    Switch = 1'b1;
    PushB  = 1'b1;
    for (int i = 0; i < 10; i++)
      step("hold_idle", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    PushB = 1'b0;
    tick();
    PushB = 1'b1;
    for (int i = 0; i < 10; i++)
      step("hold_entry", 1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
    PushB = 1'b0;
    tick();
    for (int i = 1; i < 5; i++)
      press(GOOD[5-i], "hold.bit", 1'b0, 1'b0, 1'b0, 3'(i + 1), 2'd0);
    press(GOOD[0], "hold.last", 1'b1, 1'b0, 1'b0, 3'd6, 2'd0);
    Logout = 1'b1;
    step("logout3", 1'b0, 1'b0, 1'b0, 3'd6, 2'd0);
    Logout = 1'b0;

    // Reset mid-lockout.
    attempt(6'b000000, "lk1", 2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    attempt(6'b000000, "lk2", 2'd1, 1'b0, 1'b0, 1'b1, 2'd2);
    attempt(6'b000000, "lk3", 2'd2, 1'b0, 1'b1, 1'b1, 2'd3);
    tick();
    Rst = 1'b1;
    step("rst_lock", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    Rst = 1'b0;
    step("rst_lock_after", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

    // Entry idle behaviour with one prior failure on record.
    attempt(6'b111111, "pre_tmo", 2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    press(1'b0, "tmo.start", 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);
    press(GOOD[5], "tmo.bit1", 1'b0, 1'b0, 1'b0, 3'd1, 2'd1);
    press(GOOD[4], "tmo.bit2", 1'b0, 1'b0, 1'b0, 3'd2, 2'd1);
`ifdef ACCESS_TIMEOUT_EN
    for (int i = 0; i < 18; i++)
      step("tmo_wait", 1'b0, 1'b0, 1'b0, 3'd2, 2'd1);
    step("tmo_abort", 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);
    press(1'b1, "tmo_idle_start", 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);
    for (int i = 0; i < 5; i++)
      press(GOOD[5-i], "tmo_re.bit", 1'b0, 1'b0, 1'b0, 3'(i + 1), 2'd1);
    press(GOOD[0], "tmo_re.last", 1'b1, 1'b0, 1'b0, 3'd6, 2'd0);
`else
    for (int i = 0; i < 30; i++)
      step("no_tmo_wait", 1'b0, 1'b0, 1'b0, 3'd2, 2'd1);
    for (int i = 2; i < 5; i++)
      press(GOOD[5-i], "no_tmo.bit", 1'b0, 1'b0, 1'b0, 3'(i + 1), 2'd1);
    press(GOOD[0], "no_tmo.last", 1'b1, 1'b0, 1'b0, 3'd6, 2'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
